xy2_100_rx: RTL and testbench

Receiver for the XY2-100 galvo command bus (xy_sync, xy_clk, xy_x, xy_y). It oversamples the asynchronous 2 MHz bus with the 20 MHz system clock and deframes the 20-bit X and Y words. It checks control bits and parity, and publishes the 16-bit position setpoints that drive `pos_pre` of the X/Y position PID loops. It also drives the `xy_status` link-health pin back to the host.

---
 rtl/xy2_100_rx_pkg.sv | 22 ++
 rtl/xy2_sync.sv | 38 +++
 rtl/xy2_100_rx.sv | 150 +++++++++++++++
 tb/tb_xy2_100_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xy2_100_rx_pkg.sv
// Shared definitions for the XY2-100 receiver: frame geometry, control pattern,
// FSM encoding and the per-axis frame check.
package xy2_100_rx_pkg;

    localparam int         XY2_FRAME_BITS = 20;
    localparam logic [2:0] XY2_CTRL_16B   = 3'b001;
    // Shift register holds C2..C0 and D15..D0; the parity bit is captured separately.
    localparam int         SR_W           = XY2_FRAME_BITS - 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } xy2_state_e;

    function automatic logic axis_ok(input logic [SR_W-1:0] sr,
                                     input logic            par,
                                     input logic [2:0]      ctrl);
        return (sr[SR_W-1 -: 3] == ctrl) && ((^sr ^ par) == 1'b0);
    endfunction

endpackage

// File: rtl/xy2_sync.sv
// 2-FF synchronizer bank for the four XY2-100 bus lines plus the bus-clock
// falling-edge detector; sync/x/y are presented alongside the edge strobe.
module xy2_sync (
    input  logic clk_ref,
    input  logic sys_rstn,
    input  logic xy_sync,
    input  logic xy_clk,
    input  logic xy_x,
    input  logic xy_y,
    output logic bit_evt,
    output logic s_sync,
    output logic s_x,
    output logic s_y
);

    // Bit order in the bank: {sync, clk, x, y}
    logic [3:0] meta;
    logic [3:0] stab;
    logic       clk_prev;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            meta     <= '0;
            stab     <= '0;
            clk_prev <= 1'b0;
        end else begin
            meta     <= {xy_sync, xy_clk, xy_x, xy_y};
            stab     <= meta;
            clk_prev <= stab[2];
        end
    end

    assign bit_evt = clk_prev & ~stab[2];
    assign s_sync  = stab[3];
    assign s_x     = stab[1];
    assign s_y     = stab[0];

endmodule

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo bus receiver: deframes X/Y words, validates control and parity,
// publishes position setpoints and tracks link health with a watchdog.
module xy2_100_rx
    import xy2_100_rx_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 2000,
    parameter logic [2:0] CTRL_EXPECT    = XY2_CTRL_16B
) (
    input  logic        clk_ref,
    input  logic        sys_rstn,
    input  logic        xy_sync,
    input  logic        xy_clk,
    input  logic        xy_x,
    input  logic        xy_y,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        pos_valid,
    output logic        frame_err,
    output logic [15:0] err_cnt,
    output logic        link_ok,
    output logic        xy_status
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]       LAST_BIT = 5'(SR_W);

    logic bit_evt, s_sync, s_x, s_y;

    xy2_sync u_sync (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .xy_sync  (xy_sync),
        .xy_clk   (xy_clk),
        .xy_x     (xy_x),
        .xy_y     (xy_y),
        .bit_evt  (bit_evt),
        .s_sync   (s_sync),
        .s_x      (s_x),
        .s_y      (s_y)
    );

    xy2_state_e state, state_nxt;
    logic [4:0]      bit_cnt;
    logic [SR_W-1:0] sr_x, sr_y;
    logic            par_x, par_y;
    logic            shift_en, cnt_clr, cap_par, fr_err, chk;
    logic            accept, reject;
    logic [WD_W-1:0] wd_cnt, wd_nxt;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) state <= HUNT;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT:  if (bit_evt && !s_sync) state_nxt = RECV;
            RECV:  if (bit_evt && bit_cnt == LAST_BIT) state_nxt = s_sync ? HUNT : CHECK;
            CHECK: state_nxt = RECV;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        cap_par  = 1'b0;
        fr_err   = 1'b0;
        chk      = 1'b0;
        unique case (state)
            HUNT: cnt_clr = bit_evt & ~s_sync;
            RECV: if (bit_evt) begin
                if (s_sync) begin
                    if (bit_cnt == LAST_BIT) fr_err   = 1'b1;
                    else                     shift_en = 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    cap_par = 1'b1;
                end else begin
                    // SYNC low with an empty counter is just an idle gap
                    cnt_clr = 1'b1;
                    fr_err  = (bit_cnt != 5'd0);
                end
            end
            CHECK: begin
                chk     = 1'b1;
                cnt_clr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            bit_cnt <= '0;
            sr_x    <= '0;
            sr_y    <= '0;
            par_x   <= 1'b0;
            par_y   <= 1'b0;
        end else begin
            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 5'd1;
            if (shift_en) begin
                sr_x <= {sr_x[SR_W-2:0], s_x};
                sr_y <= {sr_y[SR_W-2:0], s_y};
            end
            if (cap_par) begin
                par_x <= s_x;
                par_y <= s_y;
            end
        end
    end

    // Both axes must pass or neither is published
    assign accept = chk && axis_ok(sr_x, par_x, CTRL_EXPECT) && axis_ok(sr_y, par_y, CTRL_EXPECT);
    assign reject = (chk && !accept) || fr_err;

    always_comb begin
        if (accept)                wd_nxt = '0;
        else if (wd_cnt == WD_MAX) wd_nxt = wd_cnt;
        else                       wd_nxt = wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pos_x     <= '0;
            pos_y     <= '0;
            pos_valid <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            wd_cnt    <= '0;
            link_ok   <= 1'b0;
        end else begin
            pos_valid <= accept;
            frame_err <= reject;
            if (accept) begin
                pos_x <= sr_x[15:0];
                pos_y <= sr_y[15:0];
            end
            if (reject && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            wd_cnt <= wd_nxt;
            if (accept)                link_ok <= 1'b1;
            else if (wd_nxt == WD_MAX) link_ok <= 1'b0;
        end
    end

    assign xy_status = link_ok;

endmodule

// File: tb/tb_xy2_100_rx.sv
// Self-checking bench for xy2_100_rx: drives XY2-100 frames at 2 MHz and
// compares outputs against a frame-level model of acceptance and error counting.
`timescale 1ns/1ps
module tb_xy2_100_rx;

    localparam int TO = 2000;

    logic        clk_ref = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        xy_sync = 1'b0, xy_clk = 1'b1, xy_x = 1'b0, xy_y = 1'b0;
    logic [15:0] pos_x, pos_y, err_cnt;
    logic        pos_valid, frame_err, link_ok, xy_status;

    int total = 0, bad = 0;
    int cyc = 0, fall_cyc = 0;
    int pv_cnt = 0, fe_cnt = 0, pv_cyc = 0, lo_cyc = -1;
    logic lo_prev = 1'b0;
    logic [15:0] exp_x = 16'h0, exp_y = 16'h0, exp_err = 16'h0;

    xy2_100_rx #(.TIMEOUT_CYCLES(TO), .CTRL_EXPECT(3'b001)) dut (
        .clk_ref   (clk_ref),
        .sys_rstn  (sys_rstn),
        .xy_sync   (xy_sync),
        .xy_clk    (xy_clk),
        .xy_x      (xy_x),
        .xy_y      (xy_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .link_ok   (link_ok),
        .xy_status (xy_status)
    );

    always #25 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk_ref) begin
        if (pos_valid) begin pv_cnt++; pv_cyc = cyc; end
        if (frame_err) fe_cnt++;
        if (lo_prev && !link_ok) lo_cyc = cyc;
        lo_prev = link_ok;
    end

    // Word layout: {C2..C0, D15..D0, P}, even parity over all 20 bits
    function automatic logic [19:0] mk_word(input logic [2:0] c, input logic [15:0] d, input logic flip);
        logic [18:0] b;
        b = {c, d};
        return {b, (^b) ^ flip};
    endfunction

    function automatic logic word_ok(input logic [19:0] w);
        return (w[19:17] == 3'b001) && ((^w) == 1'b0);
    endfunction

    task automatic send_bits(input logic [19:0] wx, input logic [19:0] wy,
                             input int first, input int last, input int sync_low_from);
        for (int i = first; i <= last; i++) begin
            xy_clk  = 1'b1;
            xy_sync = (i < sync_low_from);
            xy_x    = wx[19-i];
            xy_y    = wy[19-i];
            #250;
            xy_clk   = 1'b0;
            fall_cyc = cyc;
            #250;
        end
        xy_clk = 1'b1;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_ref);
    endtask

    // Sends a well-framed frame and updates the model with its predicted outcome
    task automatic send_frame(input logic [19:0] wx, input logic [19:0] wy);
        send_bits(wx, wy, 0, 19, 19);
        if (word_ok(wx) && word_ok(wy)) begin
            exp_x = wx[16:1];
            exp_y = wy[16:1];
        end else if (exp_err != 16'hFFFF) begin
            exp_err = exp_err + 16'd1;
        end
        settle();
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0;
        repeat (4) @(negedge clk_ref);
        total++;
        if ({pos_x, pos_y, err_cnt} !== 48'h0) begin
            bad++; $display("FAIL reset_regs got x=%h y=%h err=%h want 0", pos_x, pos_y, err_cnt);
        end
        total++;
        if ({pos_valid, frame_err, link_ok, xy_status} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got %b want 0000", {pos_valid, frame_err, link_ok, xy_status});
        end
        #7 sys_rstn = 1'b1;
        repeat (4) @(negedge clk_ref);
    endtask

    task automatic test_frame1();
        int pv0, fe0, lat;
        for (int k = 0; k < 3; k++) send_bits(20'h0, 20'h0, 0, 19, 0);
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk_word(3'b001, 16'h1234, 1'b0), mk_word(3'b001, 16'hABCD, 1'b0));
        lat = pv_cyc - fall_cyc;
        total++;
        if (pv_cnt - pv0 !== 1 || fe_cnt - fe0 !== 0) begin
            bad++; $display("FAIL f1_pulses got pv=%0d fe=%0d want 1 0", pv_cnt - pv0, fe_cnt - fe0);
        end
        total++;
        if (pos_x !== 16'h1234 || pos_y !== 16'hABCD) begin
            bad++; $display("FAIL f1_pos got %h %h want 1234 abcd", pos_x, pos_y);
        end
        total++;
        if (link_ok !== 1'b1 || xy_status !== 1'b1 || err_cnt !== 16'h0) begin
            bad++; $display("FAIL f1_link got ok=%b st=%b err=%h want 1 1 0", link_ok, xy_status, err_cnt);
        end
        total++;
        if (lat < 3 || lat > 5) begin
            bad++; $display("FAIL f1_latency got %0d want 4+-1", lat);
        end
    endtask

    task automatic test_parity();
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk_word(3'b001, 16'h5555, 1'b0), mk_word(3'b001, 16'h0F0F, 1'b1));
        total++;
        if (pv_cnt - pv0 !== 0 || fe_cnt - fe0 !== 1) begin
            bad++; $display("FAIL parity_pulses got pv=%0d fe=%0d want 0 1", pv_cnt - pv0, fe_cnt - fe0);
        end
        total++;
        if (pos_x !== 16'h1234 || pos_y !== 16'hABCD || err_cnt !== 16'd1) begin
            bad++; $display("FAIL parity_hold got %h %h err=%0d want 1234 abcd 1", pos_x, pos_y, err_cnt);
        end
    endtask

    task automatic test_ctrl();
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk_word(3'b010, 16'h7777, 1'b0), mk_word(3'b001, 16'h8888, 1'b0));
        total++;
        if (pv_cnt - pv0 !== 0 || fe_cnt - fe0 !== 1) begin
            bad++; $display("FAIL ctrl_pulses got pv=%0d fe=%0d want 0 1", pv_cnt - pv0, fe_cnt - fe0);
        end
        total++;
        if (pos_x !== 16'h1234 || pos_y !== 16'hABCD || err_cnt !== 16'd2) begin
            bad++; $display("FAIL ctrl_hold got %h %h err=%0d want 1234 abcd 2", pos_x, pos_y, err_cnt);
        end
    endtask

    task automatic test_framing();
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_bits(mk_word(3'b001, 16'h4321, 1'b0), mk_word(3'b001, 16'h9999, 1'b0), 0, 19, 10);
        exp_err = exp_err + 16'd1;
        settle();
        total++;
        if (pv_cnt - pv0 !== 0 || fe_cnt - fe0 !== 1 || err_cnt !== 16'd3) begin
            bad++; $display("FAIL framing got pv=%0d fe=%0d err=%0d want 0 1 3", pv_cnt - pv0, fe_cnt - fe0, err_cnt);
        end
        pv0 = pv_cnt;
        send_frame(mk_word(3'b001, 16'h0001, 1'b0), mk_word(3'b001, 16'hFFFF, 1'b0));
        total++;
        if (pv_cnt - pv0 !== 1 || pos_x !== 16'h0001 || pos_y !== 16'hFFFF) begin
            bad++; $display("FAIL framing_recover got pv=%0d %h %h want 1 0001 ffff", pv_cnt - pv0, pos_x, pos_y);
        end
    endtask

    task automatic test_random();
        logic [19:0] wx, wy;
        int pv0, fe0, mode;
        logic good;
        for (int n = 0; n < 16; n++) begin
            mode = $urandom_range(0, 3);
            wx = mk_word(3'b001, 16'($urandom), 1'b0);
            wy = mk_word(3'b001, 16'($urandom), 1'b0);
            if (mode == 1) begin
                if ($urandom_range(0, 1) == 1) wx[0] = ~wx[0]; else wy[0] = ~wy[0];
            end else if (mode == 2) begin
                if ($urandom_range(0, 1) == 1) wx = mk_word(3'($urandom_range(2, 7)), wx[16:1], 1'b0);
                else                           wy = mk_word(3'($urandom_range(2, 7)), wy[16:1], 1'b0);
            end
            good = word_ok(wx) && word_ok(wy);
            pv0 = pv_cnt; fe0 = fe_cnt;
            send_frame(wx, wy);
            total++;
            if (pv_cnt - pv0 !== (good ? 1 : 0) || fe_cnt - fe0 !== (good ? 0 : 1)) begin
                bad++; $display("FAIL rand%0d_pulses got pv=%0d fe=%0d want good=%b", n, pv_cnt - pv0, fe_cnt - fe0, good);
            end
            total++;
            if (pos_x !== exp_x || pos_y !== exp_y || err_cnt !== exp_err) begin
                bad++; $display("FAIL rand%0d_state got %h %h err=%0d want %h %h %0d", n, pos_x, pos_y, err_cnt, exp_x, exp_y, exp_err);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk_ref);
        end
    endtask

    task automatic test_watchdog();
        send_frame(mk_word(3'b001, 16'hCAFE, 1'b0), mk_word(3'b001, 16'hBEEF, 1'b0));
        lo_cyc = -1;
        for (int k = 0; k < 3000 && lo_cyc < 0; k++) @(negedge clk_ref);
        total++;
        if (lo_cyc < 0) begin
            bad++; $display("FAIL wd_timeout link_ok=%b never dropped within 3000 cycles want drop", link_ok);
        end else if (lo_cyc - pv_cyc !== TO) begin
            bad++; $display("FAIL wd_delay got %0d cycles want %0d", lo_cyc - pv_cyc, TO);
        end
        total++;
        if (xy_status !== 1'b0 || pos_x !== 16'hCAFE || pos_y !== 16'hBEEF) begin
            bad++; $display("FAIL wd_hold got st=%b %h %h want 0 cafe beef", xy_status, pos_x, pos_y);
        end
        send_frame(mk_word(3'b001, 16'h2468, 1'b0), mk_word(3'b001, 16'h1357, 1'b0));
        total++;
        if (link_ok !== 1'b1 || xy_status !== 1'b1 || pos_x !== 16'h2468 || pos_y !== 16'h1357) begin
            bad++; $display("FAIL wd_restore got ok=%b st=%b %h %h want 1 1 2468 1357", link_ok, xy_status, pos_x, pos_y);
        end
    endtask

    task automatic test_reset_midframe();
        logic [19:0] w;
        int pv0;
        w = mk_word(3'b001, 16'h3C3C, 1'b0);
        send_bits(w, w, 0, 7, 19);
        sys_rstn = 1'b0;
        #1;
        exp_x = 16'h0; exp_y = 16'h0; exp_err = 16'h0;
        total++;
        if ({pos_x, pos_y, err_cnt} !== 48'h0 || {pos_valid, frame_err, link_ok, xy_status} !== 4'b0) begin
            bad++; $display("FAIL rst_mid got x=%h y=%h err=%h flags=%b want 0", pos_x, pos_y, err_cnt,
                            {pos_valid, frame_err, link_ok, xy_status});
        end
        repeat (3) @(negedge clk_ref);
        sys_rstn = 1'b1;
        pv0 = pv_cnt;
        send_bits(w, w, 8, 19, 19);
        settle();
        total++;
        if (pv_cnt - pv0 !== 0 || pos_x !== 16'h0) begin
            bad++; $display("FAIL rst_partial got pv=%0d x=%h want 0 0000", pv_cnt - pv0, pos_x);
        end
        send_frame(mk_word(3'b001, 16'h6A6A, 1'b0), mk_word(3'b001, 16'h9595, 1'b0));
        total++;
        if (pv_cnt - pv0 !== 1 || pos_x !== 16'h6A6A || pos_y !== 16'h9595 || link_ok !== 1'b1) begin
            bad++; $display("FAIL rst_next got pv=%0d %h %h ok=%b want 1 6a6a 9595 1", pv_cnt - pv0, pos_x, pos_y, link_ok);
        end
    endtask

    initial begin
        test_reset();
        test_frame1();
        test_parity();
        test_ctrl();
        test_framing();
        test_random();
        test_watchdog();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
